// File: rtl/ss_mem_slv.sv
// ss_mem_slv: Wishbone slave model backed by a 2^AW x 64-bit memory.
// It inserts a fixed number of wait cycles before the first ack of each
// transaction, can inject one retry every RTY_EVERY transactions, and
// flags out-of-range addresses with a one-cycle error. A backdoor port
// preloads memory contents without using the bus.
module ss_mem_slv #(
   parameter int AW        = 8,
   parameter int WAIT      = 1,
   parameter int RTY_EVERY = 0
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n_i,
   input  logic          wbm_cyc_i,
   input  logic          wbm_stb_i,
   input  logic          wbm_we_i,
   input  logic          wbm_cab_i,
   input  logic [3:0]    wbm_sel_i,
   input  logic [31:0]   wbm_adr_i,
   input  logic [31:0]   wbm_dat_i,
   input  logic [31:0]   wbm_dat64_i,
   output logic [31:0]   wbm_dat_o,
   output logic [31:0]   wbm_dat64_o,
   output logic          wbm_ack_o,
   output logic          wbm_rty_o,
   output logic          wbm_err_o,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_adr_i,
   input  logic [63:0]   ld_dat_i,
   output logic [15:0]   beat_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_BURST,
      ST_RTY,
      ST_ERR
   } state_t;

   // The transaction counter only needs to track position inside one retry
   // period, so it wraps at RTY_EVERY instead of at its full width; this
   // keeps "every Nth transaction" exact for any N.
   localparam int          RTY_PERIOD = (RTY_EVERY == 0) ? 1 : RTY_EVERY;
   localparam logic [15:0] TXN_LAST   = 16'(RTY_PERIOD - 1);
   localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT);

   state_t        state_q, state_d;
   logic          ack_q, ack_d;
   logic          rty_q, rty_d;
   logic          err_q, err_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [3:0]    wait_q, wait_d;
   logic [15:0]   txn_q, txn_d;
   logic [15:0]   beat_q, beat_d;

   logic [63:0]   mem [2**AW];
   logic [63:0]   rd_word;
   logic [31:0]   adr_hi;
   logic          out_of_range;
   logic          bus_req;
   logic [15:0]   txn_inc;
   logic          rty_hit;
   logic          unused_bits;

   assign unused_bits  = ^{wbm_sel_i, wbm_adr_i[2:0]};

   assign bus_req      = wbm_cyc_i & wbm_stb_i;
   assign adr_hi       = wbm_adr_i >> (3 + AW);
   assign out_of_range = |adr_hi;
   assign txn_inc      = (txn_q == TXN_LAST) ? 16'd0 : txn_q + 16'd1;
   assign rty_hit      = (RTY_EVERY != 0) && (txn_inc == 16'd0);

   // The registered ack is gated by the live strobe so a master that drops
   // cyc right after its last beat never sees a stray ack.
   assign wbm_ack_o    = ack_q & wbm_cyc_i & wbm_stb_i;
   assign wbm_rty_o    = rty_q;
   assign wbm_err_o    = err_q;
   assign beat_cnt_o   = beat_q;

   assign rd_word      = mem[ptr_q];
   assign wbm_dat_o    = rd_word[31:0];
   assign wbm_dat64_o  = rd_word[63:32];

   // Next-state logic: transaction decode in IDLE, wait/retry/error
   // sequencing, and beat accounting on every acked edge.
   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      rty_d   = 1'b0;
      err_d   = 1'b0;
      ptr_d   = ptr_q;
      wait_d  = wait_q;
      txn_d   = txn_q;
      beat_d  = beat_q;

      if (wbm_ack_o) begin
         ptr_d  = ptr_q + 1'b1;
         beat_d = beat_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus_req) begin
               ptr_d = wbm_adr_i[AW+2:3];
               txn_d = txn_inc;
               if (out_of_range) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else if (rty_hit) begin
                  state_d = ST_RTY;
                  rty_d   = 1'b1;
               end else if (WAIT == 0) begin
                  state_d = ST_BURST;
                  ack_d   = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  wait_d  = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!wbm_cyc_i) begin
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q - 4'd1;
               if (wait_q <= 4'd1) begin
                  state_d = ST_BURST;
                  ack_d   = 1'b1;
               end
            end
         end
         ST_RTY: begin
            if (!wbm_cyc_i) begin
               state_d = ST_IDLE;
            end else if (WAIT == 0) begin
               state_d = ST_BURST;
               ack_d   = 1'b1;
            end else begin
               state_d = ST_WAIT;
               wait_d  = WAIT_LOAD;
            end
         end
         ST_BURST: begin
            if (!wbm_cyc_i || !ack_q) begin
               state_d = ST_IDLE;
            end else if (wbm_ack_o && !wbm_cab_i) begin
               ack_d = 1'b0;
            end else begin
               ack_d = 1'b1;
            end
         end
         ST_ERR: begin
            if (!wbm_cyc_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers, cleared asynchronously so ack drops as soon as
   // reset is asserted.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         rty_q   <= 1'b0;
         err_q   <= 1'b0;
         ptr_q   <= '0;
         wait_q  <= 4'd0;
         txn_q   <= 16'd0;
         beat_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         rty_q   <= rty_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
         wait_q  <= wait_d;
         txn_q   <= txn_d;
         beat_q  <= beat_d;
      end
   end

   // Memory array (never reset); the bus write is issued last so it wins
   // over a backdoor write to the same word on the same edge.
   always_ff @(posedge wb_clk_i) begin
      if (ld_we_i) begin
         mem[ld_adr_i] <= ld_dat_i;
      end
      if (wbm_ack_o && wbm_we_i) begin
         mem[ptr_q] <= {wbm_dat64_i, wbm_dat_i};
      end
   end

endmodule

// File: tb/tb_ss_mem_slv.sv
// tb_ss_mem_slv: scoreboard bench for ss_mem_slv. The stimulus side plans
// each transaction against a plain array model of memory and pushes the
// expected responses (kind, cycle, read data) into a queue; an independent
// monitor pops and compares whenever the DUT raises ack, rty or err.
module tb_ss_mem_slv;

   localparam int AW        = 8;
   localparam int WAIT      = 1;
   localparam int RTY_EVERY = 2;
   localparam int DEPTH     = 256;

   localparam int K_ACK = 0;
   localparam int K_RTY = 1;
   localparam int K_ERR = 2;

   logic          clk;
   logic          rstN;
   logic          cyc, stb, we, cab;
   logic [3:0]    sel;
   logic [31:0]   adr, datI, dat64I;
   logic [31:0]   datO, dat64O;
   logic          ackO, rtyO, errO;
   logic          ldWe;
   logic [AW-1:0] ldAdr;
   logic [63:0]   ldDat;
   logic [15:0]   beatCnt;

   typedef struct {
      int          kind;
      int          cyc;
      logic [63:0] data;
      bit          chkData;
   } exp_t;

   exp_t        expQ[$];
   logic [63:0] refMem [DEPTH];
   logic [63:0] wdat [4];
   int          refTxn = 0;
   logic [15:0] refBeat = 16'd0;
   int          checks = 0;
   int          fails = 0;
   int          tc = 0;

   ss_mem_slv #(.AW(AW), .WAIT(WAIT), .RTY_EVERY(RTY_EVERY)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rstN),
      .wbm_cyc_i   (cyc),
      .wbm_stb_i   (stb),
      .wbm_we_i    (we),
      .wbm_cab_i   (cab),
      .wbm_sel_i   (sel),
      .wbm_adr_i   (adr),
      .wbm_dat_i   (datI),
      .wbm_dat64_i (dat64I),
      .wbm_dat_o   (datO),
      .wbm_dat64_o (dat64O),
      .wbm_ack_o   (ackO),
      .wbm_rty_o   (rtyO),
      .wbm_err_o   (errO),
      .ld_we_i     (ldWe),
      .ld_adr_i    (ldAdr),
      .ld_dat_i    (ldDat),
      .beat_cnt_o  (beatCnt)
   );

   // Free-running clock and a cycle stamp used to check response timing.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) tc <= tc + 1;

   // Single comparison point: bumps the counters and reports any miss.
   function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, tc);
      end
   endfunction

   // Reference model of one transaction: word index from the byte address,
   // range check, every RTY_EVERY-th transaction retried once, first ack
   // WAIT idle cycles after the request (one more after a retry), then one
   // beat per cycle with the index wrapping around the memory.
   function automatic void planTxn(input logic [31:0] a, input bit w, input int n, input int start);
      logic [31:0] word;
      int          first;
      int          idx;
      word = a / 8;
      refTxn++;
      if (word >= DEPTH) begin
         expQ.push_back('{K_ERR, start + 1, 64'd0, 1'b0});
         return;
      end
      first = start + 1 + WAIT;
      if (refTxn % RTY_EVERY == 0) begin
         expQ.push_back('{K_RTY, start + 1, 64'd0, 1'b0});
         first++;
      end
      for (int i = 0; i < n; i++) begin
         idx = (int'(word) + i) % DEPTH;
         expQ.push_back('{K_ACK, first + i, refMem[idx], !w});
         if (w) refMem[idx] = wdat[i];
      end
      refBeat = refBeat + 16'(n);
   endfunction

   // Monitor: every cycle that shows ack, rty or err is matched against the
   // oldest expected response.
   always @(negedge clk) begin : monitor
      exp_t e;
      int   kind;
      if (rstN && (ackO || rtyO || errO)) begin
         checkOutput("one_hot", 64'($countones({ackO, rtyO, errO})), 64'd1);
         if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_resp: got ack=%b rty=%b err=%b, expected nothing (cycle %0d)",
                     ackO, rtyO, errO, tc);
         end else begin
            e = expQ.pop_front();
            kind = ackO ? K_ACK : (rtyO ? K_RTY : K_ERR);
            checkOutput("resp_kind", 64'(kind), 64'(e.kind));
            checkOutput("resp_cycle", 64'(tc), 64'(e.cyc));
            if (kind == K_ACK && e.chkData) begin
               checkOutput("rd_data", {dat64O, datI == datI ? datO : datO}, e.data);
            end
         end
      end
   end

   // Backdoor preload of one word, mirrored into the model.
   task automatic preload(input int idx, input logic [63:0] d);
      @(posedge clk);
      #1;
      ldWe  = 1'b1;
      ldAdr = AW'(idx);
      ldDat = d;
      @(posedge clk);
      #1;
      ldWe  = 1'b0;
      refMem[idx] = d;
   endtask

   // Drives one bus transaction of n beats (data from wdat) and releases
   // cyc after the last ack or after an error; bounded by a cycle budget.
   task automatic applyStimulus(input logic [31:0] a, input bit w, input bit c, input int n, input bit collide);
      int beats;
      int guard;
      bit done;
      bit sawAck;
      bit sawErr;
      @(posedge clk);
      #1;
      cyc = 1'b1;
      stb = 1'b1;
      adr = a;
      we  = w;
      cab = c;
      {dat64I, datI} = wdat[0];
      if (collide) begin
         ldWe  = 1'b1;
         ldAdr = a[AW+2:3];
         ldDat = ~wdat[0];
      end
      planTxn(a, w, n, tc);
      beats = 0;
      guard = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge clk);
         sawAck = ackO;
         sawErr = errO;
         @(posedge clk);
         #1;
         guard++;
         if (sawAck) begin
            ldWe = 1'b0;
            beats++;
            if (beats >= n) done = 1'b1;
            else {dat64I, datI} = wdat[beats];
         end
         if (sawErr) done = 1'b1;
         if (!done && guard > 30) begin
            checks++;
            fails++;
            $display("[TB] FAIL txn_timeout: adr=%h got %0d beats, expected %0d", a, beats, n);
            expQ.delete();
            done = 1'b1;
         end
      end
      cyc  = 1'b0;
      stb  = 1'b0;
      we   = 1'b0;
      cab  = 1'b0;
      ldWe = 1'b0;
      checkOutput("beat_cnt", 64'(beatCnt), 64'(refBeat));
   endtask

   // Reset during the second beat of a four-beat read burst; ack must fall
   // at once and the counters restart, memory untouched.
   task automatic resetMidBurst(input logic [31:0] a);
      int guard;
      @(posedge clk);
      #1;
      cyc = 1'b1;
      stb = 1'b1;
      adr = a;
      we  = 1'b0;
      cab = 1'b1;
      planTxn(a, 1'b0, 4, tc);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!ackO && guard < 20);
      @(posedge clk);
      #1;
      checkOutput("ack_beat2", 64'(ackO), 64'd1);
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("ack_in_reset", 64'(ackO), 64'd0);
      checkOutput("beat_cnt_in_reset", 64'(beatCnt), 64'd0);
      cyc = 1'b0;
      stb = 1'b0;
      cab = 1'b0;
      expQ.delete();
      refTxn  = 0;
      refBeat = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   // Main sequence: reset checks, preload, directed cases, random traffic,
   // mid-burst reset, then the summary.
   initial begin
      logic [31:0] a;
      bit          w;
      bit          c;
      int          n;
      rstN = 1'b0;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cab = 1'b0;
      sel = 4'hF; adr = 32'd0; datI = 32'd0; dat64I = 32'd0;
      ldWe = 1'b0; ldAdr = '0; ldDat = 64'd0;
      for (int k = 0; k < 4; k++) wdat[k] = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ack", 64'(ackO), 64'd0);
      checkOutput("reset_rty", 64'(rtyO), 64'd0);
      checkOutput("reset_err", 64'(errO), 64'd0);
      checkOutput("reset_beat_cnt", 64'(beatCnt), 64'd0);
      rstN = 1'b1;

      for (int i = 0; i < DEPTH; i++) preload(i, {$urandom, $urandom});

      preload(4, 64'h8000_0040_0010_0003);
      applyStimulus(32'h20, 1'b0, 1'b1, 2, 1'b0);
      checkOutput("beat_cnt_two_beats", 64'(beatCnt), 64'd2);

      for (int k = 0; k < 4; k++) wdat[k] = 64'(k + 1);
      applyStimulus(32'h100, 1'b1, 1'b1, 4, 1'b0);
      applyStimulus(32'h100, 1'b0, 1'b1, 4, 1'b0);

      applyStimulus(32'h48, 1'b0, 1'b0, 1, 1'b0);
      applyStimulus(32'h50, 1'b0, 1'b0, 1, 1'b0);

      applyStimulus(32'h1000, 1'b0, 1'b0, 1, 1'b0);
      applyStimulus(32'h40, 1'b0, 1'b0, 1, 1'b0);

      applyStimulus(32'h7F8, 1'b0, 1'b1, 2, 1'b0);

      wdat[0] = {$urandom, $urandom};
      applyStimulus(32'h300, 1'b1, 1'b0, 1, 1'b1);
      applyStimulus(32'h300, 1'b0, 1'b0, 1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         if ($urandom % 5 == 0) preload(int'($urandom % DEPTH), {$urandom, $urandom});
         w = 1'($urandom % 2);
         c = 1'($urandom % 2);
         n = c ? 1 + int'($urandom % 4) : 1;
         a = {21'd0, 8'($urandom), 3'($urandom)};
         if ($urandom % 8 == 0) a[31:11] = 21'($urandom_range(1, 100000));
         for (int k = 0; k < 4; k++) wdat[k] = {$urandom, $urandom};
         applyStimulus(a, w, c, n, 1'b0);
      end

      resetMidBurst(32'h100);
      applyStimulus(32'h100, 1'b0, 1'b1, 4, 1'b0);

      repeat (3) @(posedge clk);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
